mux_scan_nto1: RTL and testbench

Parametrised, registered N:1 multiplexer with W-bit channels. It supports two modes: direct selection by `sel`, and an autonomous scan mode that steps through channels 0..N-1 with a programmable dwell time. Results go out through a single-entry valid/ready output register. It sits between a bank of sampled sources (sensors, counters, status words) and one downstream consumer, and replaces the single-bit, unclocked 16:1 selector in new designs.

---
 rtl/mux_scan_nto1.sv | 229 ++++++++++++++++++++++
 tb/tb_mux_scan_nto1.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_nto1.sv
// ----------------------------------------------------------------------------
// mux_scan_nto1
//
// Registered N:1 multiplexer with W-bit channels. There are two ways to pick
// a channel: direct selection through `sel`, or an autonomous scan that walks
// channels 0..N-1 with a programmable number of idle (dwell) cycles between
// samples. Every result lands in a single-entry valid/ready output register.
// A held sample is never overwritten before the consumer has accepted it.
//
// Optional feature macro: MUX_SCAN_PARITY_EN
//   When it is defined, the block adds an `out_parity` output. This is the
//   even parity (XOR-reduce) of the captured word, registered with out_data.
//   When it is not defined, the port and its logic do not exist.
//
// Parameters
//   N        number of input channels (2..2**SEL_W)
//   W        data width per channel
//   SEL_W    channel index width
//   DWELL_W  width of the dwell configuration and counter
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     packed channels; channel c is in_data[c*W +: W]
//   sel         channel index used in direct mode
//   mode        0 = direct, 1 = scan
//   en          capture enable
//   dwell       idle cycles between scan samples (sampled when a dwell starts)
//   out_data    registered selected data
//   out_ch      channel index belonging to out_data
//   out_valid   output register holds an unconsumed sample
//   out_ready   consumer accepts when out_valid && out_ready
//   wrap        one-cycle pulse after scan captured channel N-1
//   out_parity  (MUX_SCAN_PARITY_EN only) even parity of out_data
// ----------------------------------------------------------------------------
module mux_scan_nto1 #(
    parameter int N       = 16,
    parameter int W       = 8,
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*W-1:0]     in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               wrap
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic               out_parity
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_DWELL  = 2'd2;

    localparam int          NUM_IDX = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

`ifdef MUX_SCAN_PARITY_EN
    // Even parity of one data word: 1 when the word has an odd number of ones.
    function automatic logic parity_even(input logic [W-1:0] word);
        return ^word;
    endfunction
`endif

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [SEL_W-1:0]   ch_r;
    logic [SEL_W-1:0]   ch_nxt_s;
    logic [DWELL_W-1:0] dwell_cnt_r;
    logic [DWELL_W-1:0] dwell_cnt_nxt_s;

    logic               load_ok_s;
    logic               scan_cap_s;
    logic               direct_cap_s;
    logic               capture_s;
    logic [SEL_W-1:0]   cap_idx_s;
    logic [W-1:0]       cap_data_s;

    // The table covers every index value that sel can hold. Indices at or
    // above N read as zero, so a wide sel never selects anything outside the
    // channel bank.
    logic [W-1:0]       chan_s [NUM_IDX];

    genvar gc;
    generate
        for (gc = 0; gc < NUM_IDX; gc++) begin : g_chan
            if (gc < N) begin : g_real
                assign chan_s[gc] = in_data[gc*W +: W];
            end else begin : g_pad
                assign chan_s[gc] = {W{1'b0}};
            end
        end
    endgenerate

    // The output register accepts new data when it is empty or being drained this cycle.
    assign load_ok_s    = !out_valid || out_ready;
    assign direct_cap_s = en && !mode && load_ok_s;
    assign capture_s    = direct_cap_s || scan_cap_s;

    // Capture index: the scan channel counter in scan mode, otherwise sel.
    always_comb begin
        cap_idx_s = sel;
        if (mode) begin
            cap_idx_s = ch_r;
        end else begin
            cap_idx_s = sel;
        end
    end

    // Capture data lookup.
    always_comb begin
        cap_data_s = chan_s[cap_idx_s];
    end

    // Scan FSM next-state logic. Dropping en or mode forces IDLE, so any
    // new scan restarts at channel 0.
    always_comb begin
        state_nxt_s     = state_r;
        ch_nxt_s        = ch_r;
        dwell_cnt_nxt_s = dwell_cnt_r;
        scan_cap_s      = 1'b0;
        if (!(en && mode)) begin
            state_nxt_s     = ST_IDLE;
            ch_nxt_s        = {SEL_W{1'b0}};
            dwell_cnt_nxt_s = {DWELL_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (load_ok_s) begin
                        scan_cap_s = 1'b1;
                        if (ch_r == LAST_CH) begin
                            ch_nxt_s = {SEL_W{1'b0}};
                        end else begin
                            ch_nxt_s = ch_r + SEL_W'(1);
                        end
                        if (dwell != {DWELL_W{1'b0}}) begin
                            state_nxt_s     = ST_DWELL;
                            dwell_cnt_nxt_s = dwell;
                        end else begin
                            state_nxt_s     = ST_SAMPLE;
                        end
                    end else begin
                        // Stall: the held sample has not been taken yet.
                        state_nxt_s = ST_SAMPLE;
                    end
                end
                ST_DWELL: begin
                    dwell_cnt_nxt_s = dwell_cnt_r - DWELL_W'(1);
                    if (dwell_cnt_r <= DWELL_W'(1)) begin
                        state_nxt_s = ST_SAMPLE;
                    end else begin
                        state_nxt_s = ST_DWELL;
                    end
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    ch_nxt_s        = {SEL_W{1'b0}};
                    dwell_cnt_nxt_s = {DWELL_W{1'b0}};
                end
            endcase
        end
    end

    // Scan FSM state, channel counter and dwell counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ch_r        <= {SEL_W{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            ch_r        <= ch_nxt_s;
            dwell_cnt_r <= dwell_cnt_nxt_s;
        end
    end

    // Output register: a capture wins over a drain, so a simultaneous
    // transfer-and-capture keeps out_valid high with the new sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= {W{1'b0}};
            out_ch    <= {SEL_W{1'b0}};
            out_valid <= 1'b0;
        end else if (capture_s) begin
            out_data  <= cap_data_s;
            out_ch    <= cap_idx_s;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Wrap pulse: high for the one cycle after the scan captures the last channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= scan_cap_s && (ch_r == LAST_CH);
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    // Parity register: updated together with out_data on every capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (capture_s) begin
            out_parity <= parity_even(cap_data_s);
        end else begin
            out_parity <= out_parity;
        end
    end
`endif

endmodule

// File: tb/tb_mux_scan_nto1.sv
// ----------------------------------------------------------------------------
// Testbench for mux_scan_nto1 (N=16, W=8, SEL_W=5, DWELL_W=8).
// A transaction-level reference model predicts the output register. It
// keeps "cycles to wait before the next scan sample" and "next channel" and
// does not track FSM states. A compare process checks the DUT against it on
// every falling edge. Directed sequences add hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_mux_scan_nto1;

    localparam int N       = 16;
    localparam int W       = 8;
    localparam int SEL_W   = 5;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N*W-1:0]     in_data;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic               en;
    logic [DWELL_W-1:0] dwell;
    logic [W-1:0]       out_data;
    logic [SEL_W-1:0]   out_ch;
    logic               out_valid;
    logic               out_ready;
    logic               wrap;
`ifdef MUX_SCAN_PARITY_EN
    logic               out_parity;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_scan_nto1 #(.N(N), .W(W), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .sel       (sel),
        .mode      (mode),
        .en        (en),
        .dwell     (dwell),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wrap      (wrap)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic         m_valid   = 1'b0;
    logic         m_wrap    = 1'b0;
    logic [W-1:0] m_data    = '0;
    int           m_ch      = 0;
    int           m_next_ch = 0;
    int           m_wait    = 1;

    function automatic logic [W-1:0] chan_word(input int idx);
        logic [W-1:0] w;
        w = '0;
        if (idx < N) w = in_data[idx*W +: W];
        return w;
    endfunction

    // Reference model: one update per clock edge, from the inputs before the edge.
    always @(posedge clk or negedge rst_n) begin : model_blk
        logic lok;
        logic cap;
        logic scan;
        int   idx;
        if (!rst_n) begin
            m_valid = 1'b0; m_wrap = 1'b0; m_data = '0; m_ch = 0;
            m_next_ch = 0; m_wait = 1;
        end else begin
            lok = !m_valid || out_ready;
            cap = 1'b0; scan = 1'b0; idx = 0;
            if (en && mode) begin
                if (m_wait > 0) m_wait--;
                else if (lok) begin
                    cap = 1'b1; scan = 1'b1; idx = m_next_ch;
                    m_next_ch = (m_next_ch + 1) % N;
                    m_wait = int'(dwell);
                end
            end else begin
                m_next_ch = 0; m_wait = 1;
                if (en && lok) begin cap = 1'b1; idx = int'(sel); end
            end
            m_wrap = scan && (idx == N - 1);
            if (cap) begin
                m_data = chan_word(idx); m_ch = idx; m_valid = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare process: outputs are registered, so they are checked on every falling edge.
    always @(negedge clk) begin
        chk("cmp_valid", out_valid, m_valid);
        chk("cmp_ch", out_ch, m_ch);
        chk("cmp_data", out_data, m_data);
        chk("cmp_wrap", wrap, m_wrap);
`ifdef MUX_SCAN_PARITY_EN
        chk("cmp_parity", out_parity, ^m_data);
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        int n;
        int total;
        logic [SEL_W-1:0] prev;

        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; dwell = '0; out_ready = 1'b1;
        for (int c = 0; c < N; c++) in_data[c*W +: W] = W'(8'h10 + c);
        step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_wrap", wrap, 0);
        rst_n = 1'b1;
        step(); step();
        chk("idle_valid", out_valid, 0);

        // Direct mode.
        en = 1'b1; sel = 5'd5; step();
        chk("dir_data", out_data, 32'h15);
        chk("dir_ch", out_ch, 5);
        chk("dir_valid", out_valid, 1);
        sel = 5'd17; step();
        chk("dir_oob_data", out_data, 0);
        chk("dir_oob_ch", out_ch, 17);
        chk("dir_oob_valid", out_valid, 1);
        out_ready = 1'b0; sel = 5'd3; step();
        chk("dir_hold_ch", out_ch, 17);
        en = 1'b0; out_ready = 1'b1; step();
        chk("dir_drain_valid", out_valid, 0);
        chk("dir_drain_ch", out_ch, 17);

        // Scan, no dwell.
        mode = 1'b1; en = 1'b1; dwell = 8'd0; step();
        chk("scan_lat_valid", out_valid, 0);
        for (int i = 0; i <= 16; i++) begin
            step();
            chk("scan0_ch", out_ch, i % 16);
            chk("scan0_data", out_data, 32'h10 + (i % 16));
            chk("scan0_wrap", wrap, (i == 15) ? 1 : 0);
        end

        // Scan with dwell = 3.
        en = 1'b0; step();
        dwell = 8'd3; en = 1'b1; step(); step();
        chk("dw_first_ch", out_ch, 0);
        chk("dw_first_valid", out_valid, 1);
        total = 0;
        for (int k = 1; k <= 16; k++) begin
            prev = out_ch; n = 0;
            do begin step(); n++; end while (out_ch == prev && n < 10);
            chk("dw_gap", n, 4);
            chk("dw_ch", out_ch, k % 16);
            chk("dw_wrap", wrap, (k == 15) ? 1 : 0);
            total += n;
        end
        chk("dw_sweep", total, 64);

        // Backpressure in scan mode.
        en = 1'b0; dwell = 8'd0; step();
        en = 1'b1; step(); step();
        chk("bp_ch0", out_ch, 0);
        step();
        chk("bp_ch1", out_ch, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_ch", out_ch, 1);
            chk("bp_hold_data", out_data, 32'h11);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1; step();
        chk("bp_rel_ch2", out_ch, 2);
        chk("bp_rel_valid", out_valid, 1);
        step();
        chk("bp_rel_ch3", out_ch, 3);

        // Mode change mid-scan.
        mode = 1'b0; sel = 5'd9; step();
        chk("mc_direct_ch", out_ch, 9);
        mode = 1'b1; step();
        chk("mc_idle_valid", out_valid, 0);
        step();
        chk("mc_restart_ch", out_ch, 0);

        // Asynchronous reset mid-scan.
        step(); step();
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ch", out_ch, 0);
        chk("ar_data", out_data, 0);
        chk("ar_wrap", wrap, 0);
        step();
        rst_n = 1'b1; step();
        chk("ar_rel_valid", out_valid, 0);
        step();
        chk("ar_restart_ch", out_ch, 0);
        chk("ar_restart_valid", out_valid, 1);

`ifdef MUX_SCAN_PARITY_EN
        mode = 1'b0;
        in_data[2*W +: W] = 8'h07;
        in_data[3*W +: W] = 8'h03;
        sel = 5'd2; step();
        chk("par_07", out_parity, 1);
        sel = 5'd3; step();
        chk("par_03", out_parity, 0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
